// File: rtl/sample_framer.sv
// sample_framer: UART byte stream -> stereo sample frames.
// Frame: SYNC, L lo, L hi, R lo, R hi, XOR checksum.
module sample_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        received,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        in_frame,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_DATA,
    S_CHECK
  } state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [7:0]      chk_acc;
  logic [3:0][7:0] dat;
  logic [TW-1:0]   tcnt;

  logic in_fr_st;
  logic timed_out;
  logic chk_hit;
  logic good;
  logic bad;
  logic err_evt;

  assign in_fr_st  = (state == S_DATA) || (state == S_CHECK);
  assign timed_out = in_fr_st && !received && (tcnt == T_LAST);
  assign chk_hit   = (state == S_CHECK) && received;
  assign good      = chk_hit && (rx_byte == chk_acc);
  assign bad       = chk_hit && (rx_byte != chk_acc);
  assign err_evt   = bad || timed_out;

  // Frame parser: state, byte index, running XOR, timeout, errors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_HUNT;
      idx      <= 2'd0;
      chk_acc  <= 8'h00;
      dat      <= '0;
      tcnt     <= '0;
      in_frame <= 1'b0;
      err_cnt  <= 8'h00;
    end else begin
      unique case (state)
        S_HUNT: begin
          tcnt <= '0;
          if (received && rx_byte == SYNC_BYTE) begin
            state    <= S_DATA;
            idx      <= 2'd0;
            chk_acc  <= 8'h00;
            in_frame <= 1'b1;
          end
        end
        S_DATA: begin
          if (received) begin
            tcnt     <= '0;
            dat[idx] <= rx_byte;
            chk_acc  <= chk_acc ^ rx_byte;
            idx      <= idx + 2'd1;
            if (idx == 2'd3)
              state <= S_CHECK;
          end else if (timed_out) begin
            state    <= S_HUNT;
            in_frame <= 1'b0;
            tcnt     <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (received || timed_out) begin
            state    <= S_HUNT;
            in_frame <= 1'b0;
            tcnt     <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state    <= S_HUNT;
          in_frame <= 1'b0;
          tcnt     <= '0;
        end
      endcase
      if (err_evt && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  // Output slot: load good frames, drop when full and stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_left  <= 16'h0000;
      out_right <= 16'h0000;
      out_valid <= 1'b0;
      drop_cnt  <= 8'h00;
    end else if (good) begin
      if (!out_valid || out_ready) begin
        out_left  <= {dat[1], dat[0]};
        out_right <= {dat[3], dat[2]};
        out_valid <= 1'b1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: table vectors, corner sequences,
// and random traffic against a frame-level model.
module tb_sample_framer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        received = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        out_valid;
  logic        in_frame;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  sample_framer #(
    .SYNC_BYTE(SYNC),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_byte(rx_byte),
    .received(received),
    .out_left(out_left),
    .out_right(out_right),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_frame(in_frame),
    .err_cnt(err_cnt),
    .drop_cnt(drop_cnt)
  );

  // frame-level reference model
  bit          m_in;
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_v;
  logic [15:0] m_l;
  logic [15:0] m_r;
  int          m_err;
  int          m_drop;

  task automatic m_reset();
    m_in = 0;
    m_q.delete();
    m_idle = 0;
    m_v = 0;
    m_l = 16'h0;
    m_r = 16'h0;
    m_err = 0;
    m_drop = 0;
  endtask

  task automatic m_step(input bit rcv, input logic [7:0] b,
                        input bit rdy);
    bit          xfer;
    bit          good;
    logic [15:0] nl;
    logic [15:0] nr;
    xfer = m_v && rdy;
    good = 0;
    nl = 16'h0;
    nr = 16'h0;
    if (!m_in) begin
      m_idle = 0;
      if (rcv && b == SYNC) begin
        m_in = 1;
        m_q.delete();
      end
    end else if (rcv) begin
      m_idle = 0;
      if (m_q.size() < 4) begin
        m_q.push_back(b);
      end else begin
        if (b == (m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3])) begin
          good = 1;
          nl = {m_q[1], m_q[0]};
          nr = {m_q[3], m_q[2]};
        end else if (m_err < 255) begin
          m_err++;
        end
        m_in = 0;
      end
    end else if (m_idle == TMO - 1) begin
      m_in = 0;
      m_idle = 0;
      if (m_err < 255) m_err++;
    end else begin
      m_idle++;
    end
    if (good) begin
      if (!m_v || rdy) begin
        m_v = 1;
        m_l = nl;
        m_r = nr;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end else if (xfer) begin
      m_v = 0;
    end
  endtask

  task automatic cmp(input string nm, input bit ev,
                     input logic [15:0] el, input logic [15:0] er,
                     input bit ef, input logic [7:0] ee,
                     input logic [7:0] ed);
    vecs++;
    if (out_valid !== ev || out_left !== el ||
        out_right !== er || in_frame !== ef ||
        err_cnt !== ee || drop_cnt !== ed) begin
      miss++;
      $display("FAIL %s: got v=%0b l=%h r=%h f=%0b e=%0d d=%0d, want v=%0b l=%h r=%h f=%0b e=%0d d=%0d",
               nm, out_valid, out_left, out_right, in_frame,
               err_cnt, drop_cnt, ev, el, er, ef, ee, ed);
    end
  endtask

  task automatic cmp_model(input string nm);
    cmp(nm, m_v, m_l, m_r, m_in, 8'(m_err), 8'(m_drop));
  endtask

  task automatic cycle(input bit rcv, input logic [7:0] b,
                       input bit rdy);
    received = rcv;
    rx_byte = b;
    out_ready = rdy;
    @(posedge clk);
    m_step(rcv, b, rdy);
    #1;
    received = 1'b0;
  endtask

  task automatic step(input string nm, input bit rcv,
                      input logic [7:0] b, input bit rdy);
    cycle(rcv, b, rdy);
    cmp_model(nm);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    received = 1'b0;
    #1;
    cmp("reset", 0, 16'h0, 16'h0, 0, 8'h0, 8'h0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic frame(input string nm, input logic [7:0] l0,
                       input logic [7:0] l1, input logic [7:0] r0,
                       input logic [7:0] r1, input logic [7:0] x,
                       input bit rdy);
    step(nm, 1, SYNC, rdy);
    step(nm, 1, l0, rdy);
    step(nm, 1, l1, rdy);
    step(nm, 1, r0, rdy);
    step(nm, 1, r1, rdy);
    step(nm, 1, l0 ^ l1 ^ r0 ^ r1 ^ x, rdy);
  endtask

  typedef struct {
    bit          rcv;
    logic [7:0]  b;
    bit          rdy;
    bit          v;
    logic [15:0] l;
    logic [15:0] r;
    bit          f;
    logic [7:0]  e;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rcv, logic [7:0] b, bit rdy,
                              bit v, logic [15:0] l,
                              logic [15:0] r, bit f,
                              logic [7:0] e, logic [7:0] d);
    vec_t t;
    t.rcv = rcv; t.b = b; t.rdy = rdy;
    t.v = v; t.l = l; t.r = r;
    t.f = f; t.e = e; t.d = d;
    tbl.push_back(t);
  endfunction

  function automatic logic [7:0] rb();
    return 8'($urandom);
  endfunction

  task automatic rsend(input logic [7:0] b);
    repeat ($urandom % 3)
      step("rand", 0, rb(), ($urandom % 4) != 0);
    step("rand", 1, b, ($urandom % 4) != 0);
  endtask

  initial begin
    logic [7:0] d[4];
    int mode;

    m_reset();
    // decode, bad checksum, garbage, sync-as-data, stall/drop
    add(1, 8'hA5, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(1, 8'h34, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(1, 8'h12, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(1, 8'h78, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(1, 8'h56, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(1, 8'h08, 0, 1, 16'h1234, 16'h5678, 0, 0, 0);
    add(0, 8'h00, 0, 1, 16'h1234, 16'h5678, 0, 0, 0);
    add(0, 8'h00, 1, 0, 16'h1234, 16'h5678, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 16'h1234, 16'h5678, 1, 0, 0);
    add(1, 8'h34, 0, 0, 16'h1234, 16'h5678, 1, 0, 0);
    add(1, 8'h12, 0, 0, 16'h1234, 16'h5678, 1, 0, 0);
    add(1, 8'h78, 0, 0, 16'h1234, 16'h5678, 1, 0, 0);
    add(1, 8'h56, 0, 0, 16'h1234, 16'h5678, 1, 0, 0);
    add(1, 8'h09, 0, 0, 16'h1234, 16'h5678, 0, 1, 0);
    add(1, 8'h00, 0, 0, 16'h1234, 16'h5678, 0, 1, 0);
    add(1, 8'hFF, 0, 0, 16'h1234, 16'h5678, 0, 1, 0);
    add(1, 8'h5A, 0, 0, 16'h1234, 16'h5678, 0, 1, 0);
    add(1, 8'hA5, 0, 0, 16'h1234, 16'h5678, 1, 1, 0);
    add(1, 8'hA5, 0, 0, 16'h1234, 16'h5678, 1, 1, 0);
    add(1, 8'h00, 0, 0, 16'h1234, 16'h5678, 1, 1, 0);
    add(1, 8'hA5, 0, 0, 16'h1234, 16'h5678, 1, 1, 0);
    add(1, 8'h00, 0, 0, 16'h1234, 16'h5678, 1, 1, 0);
    add(1, 8'h00, 0, 1, 16'h00A5, 16'h00A5, 0, 1, 0);
    add(1, 8'hA5, 0, 1, 16'h00A5, 16'h00A5, 1, 1, 0);
    add(1, 8'h34, 0, 1, 16'h00A5, 16'h00A5, 1, 1, 0);
    add(1, 8'h12, 0, 1, 16'h00A5, 16'h00A5, 1, 1, 0);
    add(1, 8'h78, 0, 1, 16'h00A5, 16'h00A5, 1, 1, 0);
    add(1, 8'h56, 0, 1, 16'h00A5, 16'h00A5, 1, 1, 0);
    add(1, 8'h08, 0, 1, 16'h00A5, 16'h00A5, 0, 1, 1);
    add(0, 8'h00, 0, 1, 16'h00A5, 16'h00A5, 0, 1, 1);
    add(0, 8'h00, 1, 0, 16'h00A5, 16'h00A5, 0, 1, 1);
    add(1, 8'hA5, 0, 0, 16'h00A5, 16'h00A5, 1, 1, 1);
    add(1, 8'h11, 0, 0, 16'h00A5, 16'h00A5, 1, 1, 1);
    add(1, 8'h22, 0, 0, 16'h00A5, 16'h00A5, 1, 1, 1);
    add(1, 8'h33, 0, 0, 16'h00A5, 16'h00A5, 1, 1, 1);
    add(1, 8'h44, 0, 0, 16'h00A5, 16'h00A5, 1, 1, 1);
    add(1, 8'h44, 0, 1, 16'h2211, 16'h4433, 0, 1, 1);
    add(1, 8'hA5, 0, 1, 16'h2211, 16'h4433, 1, 1, 1);
    add(1, 8'h01, 0, 1, 16'h2211, 16'h4433, 1, 1, 1);
    add(1, 8'h02, 0, 1, 16'h2211, 16'h4433, 1, 1, 1);
    add(1, 8'h03, 0, 1, 16'h2211, 16'h4433, 1, 1, 1);
    add(1, 8'h04, 0, 1, 16'h2211, 16'h4433, 1, 1, 1);
    add(1, 8'h04, 1, 1, 16'h0201, 16'h0403, 0, 1, 1);
    add(0, 8'h00, 1, 0, 16'h0201, 16'h0403, 0, 1, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rcv, tbl[i].b, tbl[i].rdy);
      cmp($sformatf("tbl%0d", i), tbl[i].v, tbl[i].l,
          tbl[i].r, tbl[i].f, tbl[i].e, tbl[i].d);
    end

    // timeout fires on the TIMEOUT-th idle cycle
    do_reset();
    step("tmo", 1, SYNC, 1);
    step("tmo", 1, 8'h34, 1);
    step("tmo", 1, 8'h12, 1);
    repeat (TMO - 1) step("tmo", 0, 8'h00, 1);
    cmp("tmo_before", 0, 16'h0, 16'h0, 1, 8'd0, 8'd0);
    step("tmo", 0, 8'h00, 1);
    cmp("tmo_fire", 0, 16'h0, 16'h0, 0, 8'd1, 8'd0);
    frame("tmo_next", 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 1);
    cmp("tmo_recover", 1, 16'h1234, 16'h5678, 0, 8'd1, 8'd0);

    // byte arriving on the timeout cycle keeps the frame
    step("race", 1, SYNC, 1);
    repeat (TMO - 1) step("race", 0, 8'h00, 1);
    step("race", 1, 8'h34, 1);
    cmp("race_byte", 0, 16'h1234, 16'h5678, 1, 8'd1, 8'd0);
    step("race", 1, 8'h12, 1);
    step("race", 1, 8'h78, 1);
    step("race", 1, 8'h56, 1);
    step("race", 1, 8'h08, 1);
    cmp("race_done", 1, 16'h1234, 16'h5678, 0, 8'd1, 8'd0);

    // reset mid-frame
    step("midrst", 1, SYNC, 0);
    step("midrst", 1, 8'h34, 0);
    step("midrst", 1, 8'h12, 0);
    do_reset();
    frame("midrst", 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 0);
    cmp("midrst_ok", 1, 16'h1234, 16'h5678, 0, 8'd0, 8'd0);

    // counter saturation
    repeat (300)
      frame("errsat", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1);
    cmp("err_sat", 0, 16'h1234, 16'h5678, 0, 8'd255, 8'd0);
    repeat (300)
      frame("dropsat", 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 0);
    cmp("drop_sat", 1, 16'h2211, 16'h4433, 0, 8'd255, 8'd255);

    // random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      mode = $urandom % 8;
      if (mode <= 4) begin
        foreach (d[k]) d[k] = rb();
        rsend(SYNC);
        foreach (d[k]) rsend(d[k]);
        rsend((d[0] ^ d[1] ^ d[2] ^ d[3]) ^
              ((mode == 4) ? 8'(1 + $urandom % 255) : 8'h00));
      end else if (mode == 5) begin
        rsend(rb());
      end else if (mode == 6) begin
        if ($urandom % 25 == 0)
          repeat (TMO + 5) step("rand", 0, rb(), 1);
        else
          repeat ($urandom % 20)
            step("rand", 0, rb(), ($urandom % 2) != 0);
      end else if ($urandom % 16 == 0) begin
        do_reset();
      end else begin
        rsend(rb());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter TIMEOUT, default 1024, the maximum clk cycles allowed between bytes inside a frame.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports as listed below.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rx_byte  input  8  byte from the UART receiver; valid when received=1.
REQ-007 SHALL have port received  input  1  one-cycle strobe per received byte.
REQ-008 SHALL have port out_left  output  16  left sample of the held frame.
REQ-009 SHALL have port out_right  output  16  right sample of the held frame.
REQ-010 SHALL have port out_valid  output  1  out_left/out_right hold an unconsumed frame.
REQ-011 SHALL have port out_ready  input  1  downstream (FIFO writer) accepts; ready = !fifo_full.
REQ-012 SHALL have port in_frame  output  1  high in states DATA and CHECK.
REQ-013 SHALL have port err_cnt  output  8  saturating count of checksum failures and timeouts.
REQ-014 SHALL have port drop_cnt  output  8  saturating count of good frames dropped because the output slot was full.

Function
REQ-015 SHALL parse the frame format SYNC_BYTE, L[7:0], L[15:8], R[7:0], R[15:8], CHK, where CHK = XOR of the four data bytes.
REQ-016 SHALL implement states HUNT, DATA and CHECK, with a 2-bit byte index used in DATA.
REQ-017 In HUNT, a byte equal to SYNC_BYTE SHALL move the FSM to DATA with index 0; any other byte SHALL be ignored.
REQ-018 In DATA, each byte SHALL be stored at the current index and update a running XOR; index 3 SHALL move the FSM to CHECK.
REQ-019 In CHECK, a byte SHALL always return the FSM to HUNT. A match SHALL produce a good frame. A mismatch SHALL increment err_cnt and discard the frame.
REQ-020 A good frame SHALL be loaded into out_left/out_right with out_valid=1 on the edge that samples the CHK strobe, so out_valid is visible the cycle after CHK.
REQ-021 Handshake: a transfer SHALL occur on an edge where out_valid=1 and out_ready=1; out_valid SHALL then fall unless a new frame loads on that same edge.
REQ-022 While out_valid=1 and out_ready=0, out_left/out_right SHALL remain stable.
REQ-023 Good frame while out_valid=1 and out_ready=0: the new frame SHALL be dropped, drop_cnt SHALL increment, and held data SHALL stay unchanged.
REQ-024 Good frame on an edge with out_valid=1 and out_ready=1: the old frame SHALL transfer, the new frame SHALL load, out_valid SHALL stay 1, and there SHALL be no drop.
REQ-025 Timeout counter: SHALL clear on every received strobe and in HUNT, and count otherwise.
REQ-026 On reaching TIMEOUT-1 in DATA or CHECK, the FSM SHALL go to HUNT and err_cnt SHALL increment.
REQ-027 err_cnt and drop_cnt SHALL saturate at 255 and never wrap.
REQ-028 A SYNC_BYTE value arriving in DATA or CHECK SHALL be treated as data or checksum, not as a resync.
REQ-029 Timeout and received on the same edge: received SHALL win, with no error counted.

Reset
REQ-030 reset_n=0 SHALL immediately force: HUNT, index 0, out_valid=0, out_left=0, out_right=0, in_frame=0, err_cnt=0, drop_cnt=0, timeout counter 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no counter change after release.
REQ-032 After reset_n rises, the first byte SHALL be processed on the first clk edge at which received=1.

Verification
REQ-033 Frame A5 34 12 78 56 (CHK 08) -> out_valid=1 one cycle after CHK, out_left=16'h1234, out_right=16'h5678.
REQ-034 Same frame with CHK=09 -> out_valid stays 0, err_cnt=1, in_frame=0 after the CHK byte.
REQ-035 out_ready=0 held, two good frames back to back -> first frame held, drop_cnt=1; then out_ready=1 for one cycle -> out_valid falls.
REQ-036 Sync plus two data bytes, then no strobe for 1024 cycles -> in_frame=0, err_cnt=1; next full frame decodes correctly.
REQ-037 Leading garbage 00 FF 5A before a good frame -> ignored, frame decodes; 300 bad frames -> err_cnt=255.
REQ-038 reset_n pulsed low after the third frame byte -> all outputs 0; a following good frame decodes normally.
